// File: rtl/common_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : common
//  Description : Pipeline control codes shared by every stage, plus the
//                fetch-stage state encoding and the bubble instruction.
//  Contents    : C_PIPE/C_STALL/C_FLUSH/C_JUMP  per-stage control codes
//                fetch_state_t                  fetch unit FSM states
//                NOP_INST                       addi x0,x0,0
//  Revision    : 1.0  initial release
// ============================================================================
package common;

   // Per-stage control code driven by the hazard controller
   localparam logic [1:0] C_PIPE  = 2'd0;
   localparam logic [1:0] C_STALL = 2'd1;
   localparam logic [1:0] C_FLUSH = 2'd2;
   localparam logic [1:0] C_JUMP  = 2'd3;

   // Fetch unit states
   //   S_REQ  : request presented on the instruction-memory port
   //   S_WAIT : one request outstanding, response will be kept
   //   S_HOLD : instruction held for the IF/ID register
   //   S_DROP : one request outstanding, response is stale
   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_DROP = 2'd3
   } fetch_state_t;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage : common
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : IF stage. Owns the PC, fetches over a valid/ready memory
//                port with at most one request in flight, and holds the
//                fetched instruction until the pipeline consumes it.
//  Ports       : clk            clock, rising edge
//                rst            synchronous reset, active low
//                if_ctrl        stage control code (C_PIPE/STALL/FLUSH/JUMP)
//                jump_pc        redirect target, used on C_JUMP
//                imem_req_*     fetch request (valid/ready/addr)
//                imem_rsp_*     fetch response (valid/data)
//                if_valid       held instruction valid
//                if_pc/if_npc   PC of held instruction and PC+4
//                if_inst        held instruction, NOP_INST when invalid
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_unit #(
   parameter int unsigned       DWIDTH   = 32,
   parameter logic [DWIDTH-1:0] RESET_PC = '0,
   parameter logic [DWIDTH-1:0] NOP_INST = DWIDTH'(32'h0000_0013)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        if_ctrl,
   input  logic [DWIDTH-1:0] jump_pc,
   output logic              imem_req_valid,
   output logic [DWIDTH-1:0] imem_req_addr,
   input  logic              imem_req_ready,
   input  logic              imem_rsp_valid,
   input  logic [DWIDTH-1:0] imem_rsp_data,
   output logic              if_valid,
   output logic [DWIDTH-1:0] if_pc,
   output logic [DWIDTH-1:0] if_npc,
   output logic [DWIDTH-1:0] if_inst
);
   import common::*;

   localparam logic [DWIDTH-1:0] PC_STEP = DWIDTH'(4);

   fetch_state_t      state_q,    state_d;
   logic [DWIDTH-1:0] pc_q,       pc_d;
   logic              if_valid_q, if_valid_d;
   logic [DWIDTH-1:0] if_pc_q,    if_pc_d;
   logic [DWIDTH-1:0] if_inst_q,  if_inst_d;
   logic              req_fire;
   logic              is_jump;

   // ------------------------------------------------------------------------
   // Next-state and request outputs
   // ------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      if_valid_d = if_valid_q;
      if_pc_d    = if_pc_q;
      if_inst_d  = if_inst_q;

      is_jump = (if_ctrl == C_JUMP);

      // Request is suppressed while reset is asserted so that memory never
      // sees a transaction the unit is about to forget.
      imem_req_valid = rst && (state_q == S_REQ);
      req_fire       = imem_req_valid && imem_req_ready;

      case (state_q)
         S_REQ: begin
            // The address only changes on a redirect; otherwise the request
            // stays stable until memory accepts it.
            if (is_jump) begin
               pc_d = jump_pc;
            end
            if (req_fire) begin
               // A redirect in the accept cycle makes the just-issued fetch
               // stale; its response must still be drained.
               state_d = is_jump ? S_DROP : S_WAIT;
            end
         end

         S_WAIT: begin
            if (is_jump) begin
               pc_d    = jump_pc;
               state_d = imem_rsp_valid ? S_REQ : S_DROP;
            end else if (imem_rsp_valid) begin
               state_d    = S_HOLD;
               if_valid_d = 1'b1;
               if_pc_d    = pc_q;
               if_inst_d  = imem_rsp_data;
            end
         end

         S_DROP: begin
            if (is_jump) begin
               pc_d = jump_pc;
            end
            if (imem_rsp_valid) begin
               state_d = S_REQ;
            end
         end

         S_HOLD: begin
            // Anything but a stall releases the hold register and refetches.
            if (if_ctrl != C_STALL) begin
               state_d    = S_REQ;
               if_valid_d = 1'b0;
               if_inst_d  = NOP_INST;
               if (if_ctrl == C_PIPE) begin
                  pc_d = pc_q + PC_STEP;
               end else if (is_jump) begin
                  pc_d = jump_pc;
               end
            end
         end

         default: begin
            state_d = S_REQ;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // PC, state and hold register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_REQ;
         pc_q       <= RESET_PC;
         if_valid_q <= 1'b0;
         if_pc_q    <= RESET_PC;
         if_inst_q  <= NOP_INST;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         if_valid_q <= if_valid_d;
         if_pc_q    <= if_pc_d;
         if_inst_q  <= if_inst_d;
      end
   end

   assign imem_req_addr = pc_q;
   assign if_valid      = if_valid_q;
   assign if_pc         = if_pc_q;
   assign if_npc        = if_pc_q + PC_STEP;
   assign if_inst       = if_inst_q;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. A small memory model
//                answers accepted fetches after a programmable latency; a
//                scoreboard holds the {pc, inst} pairs the pipeline must see.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;
   import common::*;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  if_ctrl;
   logic [31:0] jump_pc;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_npc;
   logic [31:0] if_inst;

   fetch_unit #(
      .DWIDTH   (32),
      .RESET_PC (32'h0000_0000),
      .NOP_INST (32'h0000_0013)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .if_ctrl        (if_ctrl),
      .jump_pc        (jump_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_npc         (if_npc),
      .if_inst        (if_inst)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // memory model
   logic        mem_pend = 1'b0;
   int          mem_cnt  = 0;
   int          mem_k    = 1;
   logic [31:0] mem_addr = '0;
   logic        ovr_en   = 1'b0;
   logic [31:0] ovr_data = '0;

   // scoreboard of deliveries the pipeline must observe, in order
   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } sb_t;
   sb_t sb_q[$];

   logic        prev_valid    = 1'b0;
   logic        prev_hold_req = 1'b0;
   logic [31:0] prev_addr     = '0;
   logic        inv_en        = 1'b0;

   typedef struct {
      logic        rst;
      logic [1:0]  ctrl;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
   } vec_t;
   vec_t tbl[18];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, ~a[31:16]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_fetch(input logic [31:0] pc);
      sb_t e;
      e.pc   = pc;
      e.inst = mem_word(pc);
      sb_q.push_back(e);
   endtask

   // One clock cycle: present memory response, check invariants and the
   // scoreboard, clock, then advance the memory model.
   task automatic cycle();
      logic accept;
      logic jumped;
      sb_t  e;
      imem_rsp_valid = mem_pend && (mem_cnt == 0);
      imem_rsp_data  = imem_rsp_valid ? (ovr_en ? ovr_data : mem_word(mem_addr)) : 32'hBAD0_0000;
      #1;
      assert (!imem_rsp_valid || mem_pend);
      if (inv_en) begin
         check("npc", if_npc, if_pc + 32'd4);
         if (!if_valid) check("bubble_inst", if_inst, NOP);
         check("one_outstanding", {31'd0, imem_req_valid & mem_pend}, 32'd0);
         if (prev_hold_req && rst) begin
            check("req_held_valid", {31'd0, imem_req_valid}, 32'd1);
            check("req_held_addr", imem_req_addr, prev_addr);
         end
         if (if_valid && !prev_valid) begin
            if (sb_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL sb_unexpected: got pc %h inst %h expected no delivery", if_pc, if_inst);
            end else begin
               e = sb_q.pop_front();
               check("sb_pc", if_pc, e.pc);
               check("sb_inst", if_inst, e.inst);
            end
         end
      end
      accept        = imem_req_valid && imem_req_ready;
      jumped        = (if_ctrl == C_JUMP);
      prev_hold_req = imem_req_valid && !accept && !jumped;
      prev_addr     = imem_req_addr;
      prev_valid    = if_valid;
      @(posedge clk);
      #1;
      if (!rst) begin
         mem_pend = 1'b0;
      end else begin
         if (imem_rsp_valid) mem_pend = 1'b0;
         else if (mem_pend) mem_cnt--;
         if (accept) begin
            mem_pend = 1'b1;
            mem_cnt  = mem_k - 1;
            mem_addr = prev_addr;
         end
      end
   endtask

   task automatic run_until_valid(input int max);
      int n = 0;
      while (!if_valid && n < max) begin
         cycle();
         n++;
      end
      if (!if_valid) begin
         n_vec++;
         n_err++;
         $display("FAIL fetch_timeout: if_valid=%0d after %0d cycles, required 1", if_valid, n);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running, required finish");
      $fatal(1);
   end

   initial begin
      rst            = 1'b0;
      if_ctrl        = C_PIPE;
      jump_pc        = '0;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;

      //           rst   ctrl     req   addr          vld   pc
      tbl[0]  = '{1'b0, C_PIPE,  1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000};
      tbl[1]  = '{1'b1, C_PIPE,  1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000};
      tbl[2]  = '{1'b1, C_PIPE,  1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000};
      tbl[3]  = '{1'b1, C_PIPE,  1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000};
      tbl[4]  = '{1'b1, C_PIPE,  1'b1, 32'h0000_0004, 1'b0, 32'h0000_0000};
      tbl[5]  = '{1'b1, C_PIPE,  1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000};
      tbl[6]  = '{1'b1, C_PIPE,  1'b0, 32'h0000_0000, 1'b1, 32'h0000_0004};
      tbl[7]  = '{1'b1, C_PIPE,  1'b1, 32'h0000_0008, 1'b0, 32'h0000_0000};
      tbl[8]  = '{1'b1, C_PIPE,  1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000};
      tbl[9]  = '{1'b1, C_STALL, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0008};
      tbl[10] = '{1'b1, C_STALL, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0008};
      tbl[11] = '{1'b1, C_STALL, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0008};
      tbl[12] = '{1'b1, C_STALL, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0008};
      tbl[13] = '{1'b1, C_STALL, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0008};
      tbl[14] = '{1'b1, C_PIPE,  1'b0, 32'h0000_0000, 1'b1, 32'h0000_0008};
      tbl[15] = '{1'b1, C_PIPE,  1'b1, 32'h0000_000C, 1'b0, 32'h0000_0000};
      tbl[16] = '{1'b1, C_PIPE,  1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000};
      tbl[17] = '{1'b1, C_PIPE,  1'b0, 32'h0000_0000, 1'b1, 32'h0000_000C};

      // first reset edge; the second comes from table row 0
      cycle();
      inv_en = 1'b1;

      expect_fetch(32'h0);
      expect_fetch(32'h4);
      expect_fetch(32'h8);
      expect_fetch(32'hC);

      // ---- reset, straight-line fetch, stall (table driven) ----
      for (int i = 0; i < 18; i++) begin
         rst     = tbl[i].rst;
         if_ctrl = tbl[i].ctrl;
         #1;
         check($sformatf("t%0d_req_valid", i), {31'd0, imem_req_valid}, {31'd0, tbl[i].exp_req});
         if (tbl[i].exp_req) check($sformatf("t%0d_req_addr", i), imem_req_addr, tbl[i].exp_addr);
         check($sformatf("t%0d_if_valid", i), {31'd0, if_valid}, {31'd0, tbl[i].exp_valid});
         if (tbl[i].exp_valid || !tbl[i].rst) check($sformatf("t%0d_if_pc", i), if_pc, tbl[i].exp_pc);
         if (tbl[i].exp_valid) check($sformatf("t%0d_if_inst", i), if_inst, mem_word(tbl[i].exp_pc));
         if (!tbl[i].rst) check("t_reset_inst", if_inst, NOP);
         cycle();
      end

      // ---- memory not ready: address held at 0x10 ----
      imem_req_ready = 1'b0;
      if_ctrl        = C_PIPE;
      for (int i = 0; i < 4; i++) begin
         check("nready_req_valid", {31'd0, imem_req_valid}, 32'd1);
         check("nready_addr", imem_req_addr, 32'h10);
         cycle();
      end
      imem_req_ready = 1'b1;
      expect_fetch(32'h10);
      run_until_valid(10);

      // ---- jump while waiting: stale 0xDEADBEEF must be discarded ----
      if_ctrl = C_PIPE;
      cycle();
      mem_k    = 3;
      ovr_en   = 1'b1;
      ovr_data = 32'hDEAD_BEEF;
      check("jw_req_addr", imem_req_addr, 32'h14);
      cycle();
      if_ctrl = C_JUMP;
      jump_pc = 32'h100;
      check("jw_wait_req", {31'd0, imem_req_valid}, 32'd0);
      cycle();
      if_ctrl = C_PIPE;
      for (int i = 0; i < 2; i++) begin
         check("jw_drop_req", {31'd0, imem_req_valid}, 32'd0);
         check("jw_drop_valid", {31'd0, if_valid}, 32'd0);
         cycle();
      end
      check("jw_new_req", {31'd0, imem_req_valid}, 32'd1);
      check("jw_new_addr", imem_req_addr, 32'h100);
      check("jw_no_stale", {31'd0, if_valid}, 32'd0);
      mem_k  = 1;
      ovr_en = 1'b0;
      expect_fetch(32'h100);
      run_until_valid(10);

      // ---- jump while holding, to 0x20 ----
      if_ctrl = C_JUMP;
      jump_pc = 32'h20;
      cycle();
      check("jh_valid", {31'd0, if_valid}, 32'd0);
      check("jh_addr", imem_req_addr, 32'h20);
      if_ctrl = C_PIPE;
      expect_fetch(32'h20);
      run_until_valid(10);

      // ---- flush while holding at 0x20: refetch same pc ----
      if_ctrl = C_FLUSH;
      cycle();
      if_ctrl = C_PIPE;
      check("fl_valid", {31'd0, if_valid}, 32'd0);
      check("fl_req", {31'd0, imem_req_valid}, 32'd1);
      check("fl_addr", imem_req_addr, 32'h20);
      expect_fetch(32'h20);
      run_until_valid(10);

      // ---- consume, then jump in S_REQ without and with accept ----
      cycle();
      imem_req_ready = 1'b0;
      if_ctrl        = C_JUMP;
      jump_pc        = 32'h40;
      check("jr_addr_before", imem_req_addr, 32'h24);
      cycle();
      check("jr_noacc_addr", imem_req_addr, 32'h40);
      imem_req_ready = 1'b1;
      jump_pc        = 32'h80;
      cycle();
      if_ctrl = C_PIPE;
      check("jr_acc_drop_req", {31'd0, imem_req_valid}, 32'd0);
      cycle();
      check("jr_acc_req", {31'd0, imem_req_valid}, 32'd1);
      check("jr_acc_addr", imem_req_addr, 32'h80);
      check("jr_acc_valid", {31'd0, if_valid}, 32'd0);

      // ---- reset while waiting ----
      mem_k = 3;
      cycle();
      check("rw_wait_req", {31'd0, imem_req_valid}, 32'd0);
      rst = 1'b0;
      cycle();
      check("rw_req_in_reset", {31'd0, imem_req_valid}, 32'd0);
      check("rw_valid", {31'd0, if_valid}, 32'd0);
      check("rw_if_pc", if_pc, 32'h0);
      rst = 1'b1;
      #1;
      check("rw_req_after", {31'd0, imem_req_valid}, 32'd1);
      check("rw_addr_after", imem_req_addr, 32'h0);
      mem_k = 1;
      expect_fetch(32'h0);
      run_until_valid(10);

      // ---- PC wrap ----
      if_ctrl = C_JUMP;
      jump_pc = 32'hFFFF_FFFC;
      cycle();
      check("wr_addr", imem_req_addr, 32'hFFFF_FFFC);
      if_ctrl = C_PIPE;
      expect_fetch(32'hFFFF_FFFC);
      run_until_valid(10);
      check("wr_npc", if_npc, 32'h0);
      cycle();
      check("wr_req", {31'd0, imem_req_valid}, 32'd1);
      check("wr_wrap_addr", imem_req_addr, 32'h0);

      check("sb_drained", sb_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_fetch_unit
`default_nettype wire
